muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (range 1..15).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  E-stage issue strobe for a mult/div-class instruction.
REQ-006 md_op  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-007 a  in  32  rs operand, already forwarded.
REQ-008 b  in  32  rt operand, already forwarded.
REQ-009 d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 busy  out  1  registered; high while an operation is in flight.
REQ-011 md_stall  out  1  combinational stall request to the hazard unit.
REQ-012 hi  out  32  registered HI register.
REQ-013 lo  out  32  registered LO register.

Function
REQ-014 FSM states: IDLE, MUL_RUN, DIV_RUN; 4-bit down-counter cnt.
REQ-015 IDLE, start=1, md_op in {1,2}: latch the 64-bit product (signed for 1, unsigned for 2) into pending regs; load cnt=MULT_CYCLES-1; go to MUL_RUN; busy=1 from the next cycle.
REQ-016 IDLE, start=1, md_op in {3,4}: latch quotient and remainder (signed for 3, unsigned for 4; quotient truncates toward zero, remainder takes the sign of a); load cnt=DIV_CYCLES-1; go to DIV_RUN.
REQ-017 MUL_RUN/DIV_RUN: decrement cnt each cycle; on the edge where cnt==0, write the pending result to HI/LO (mult: HI=upper 32 bits, LO=lower 32 bits; div: LO=quotient, HI=remainder), return to IDLE, and set busy=0.
REQ-018 busy is high for exactly MULT_CYCLES or DIV_CYCLES consecutive cycles per operation.
REQ-019 hi/lo hold their old values throughout busy; new values are visible in the first cycle busy=0.
REQ-020 IDLE, start=1, md_op=5/6: write a to HI or LO at that edge; busy stays 0.
REQ-021 start=1 while busy=1 is ignored with no state change; simulation assertion fires.
REQ-022 md_op 0 or 7 with start=1 is ignored.
REQ-023 DIV/DIVU with b==0: full busy duration, HI/LO left unchanged.
REQ-024 Signed DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-025 md_stall = d_is_md & (busy | (start & md_op in 1..4)).
REQ-026 Back-to-back: a new start accepted in the first cycle busy=0 sees the updated HI/LO.

Reset
REQ-027 reset=1 at a clock edge: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result discarded, including mid-operation.
REQ-028 reset has priority over start on the same edge.

Structure
REQ-029 Shared package holds the md_op encodings (MD_NONE..MD_MTLO) and the FSM state encodings, so the control decoder and the hazard unit use the same values.
REQ-030 A single sub-module md_arith (combinational signed/unsigned product and quotient/remainder) is instantiated once; the FSM, counter and HI/LO registers stay in muldiv_ctrl.

Verification
REQ-031 MULT a=0xFFFFFFFD, b=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 MULTU a=0xFFFFFFFD, b=7 -> hi=0x00000006, lo=0xFFFFFFEB after 5 busy cycles.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi/lo unchanged after 10 cycles.
REQ-034 DIV issued, second MULT pulsed at busy cycle 3 -> ignored, assertion fires, DIV result written; md_stall=1 while d_is_md=1 and busy=1.
REQ-035 MULT started, reset asserted in busy cycle 2 -> next cycle busy=0, hi=lo=0, and no later write occurs.
REQ-036 MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, busy never rises; MTLO back-to-back writes lo.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the mult/div control block: md_op values, FSM states
// and the HI/LO result payload used by the control decoder and hazard unit.
package muldiv_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_result_t;

    // Multi-cycle operations that occupy the unit and can stall decode
    function automatic logic is_long_op(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Issue/result bundle between the E-stage pipeline and the mult/div unit.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic              start;
    md_op_e            md_op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              d_is_md;
    logic              busy;
    logic              md_stall;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, md_op, a, b, d_is_md,
                    input  busy, md_stall, hi, lo);
    modport slave  (input  start, md_op, a, b, d_is_md,
                    output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_arith.sv
// Combinational signed/unsigned 32x32 product and truncating quotient/remainder.
module md_arith
    import muldiv_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              is_signed,
    output md_result_t        prod,
    output md_result_t        divres
);
    logic [2*DATA_W-1:0] ext_a, ext_b;
    logic                neg_a, neg_b;
    logic [DATA_W-1:0]   mag_a, mag_b, divisor, q_u, r_u;

    // Sign- or zero-extend so one 64-bit multiply covers both flavours
    assign ext_a = {{DATA_W{is_signed & a[DATA_W-1]}}, a};
    assign ext_b = {{DATA_W{is_signed & b[DATA_W-1]}}, b};
    assign prod  = ext_a * ext_b;

    assign neg_a   = is_signed & a[DATA_W-1];
    assign neg_b   = is_signed & b[DATA_W-1];
    assign mag_a   = neg_a ? -a : a;
    assign mag_b   = neg_b ? -b : b;
    // Divide-by-zero result is discarded by the controller; avoid an undefined divide
    assign divisor = (mag_b == '0) ? DATA_W'(1) : mag_b;
    assign q_u     = mag_a / divisor;
    assign r_u     = mag_a % divisor;

    // Quotient truncates toward zero, remainder follows the dividend's sign
    assign divres.lo = (neg_a ^ neg_b) ? -q_u : q_u;
    assign divres.hi = neg_a ? -r_u : r_u;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer with HI/LO registers and decode-stall generation.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_ctrl_if.slave   bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    md_result_t        pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    md_result_t        prod, divres;

    md_arith u_arith (
        .a         (bus.a),
        .b         (bus.b),
        .is_signed (is_signed_op(bus.md_op)),
        .prod      (prod),
        .divres    (divres)
    );

    // Next-state and register update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    unique case (bus.md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_d    = prod;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES - 1);
                            state_d   = ST_MUL_RUN;
                            busy_d    = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_d    = divres;
                            pend_wr_d = (bus.b != '0);
                            cnt_d     = CNT_W'(DIV_CYCLES - 1);
                            state_d   = ST_DIV_RUN;
                            busy_d    = 1'b1;
                        end
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (cnt_q == '0) begin
                    if (pend_wr_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_stall = bus.d_is_md & (busy_q | (bus.start & is_long_op(bus.md_op)));

    // Issue while busy is dropped by the FSM; flag it so pipeline bugs are visible
    start_while_busy: assert property (@(posedge clk) disable iff (reset) !(bus.start && busy_q))
        else $warning("muldiv_ctrl: start ignored while busy");

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed table-driven bench for muldiv_ctrl plus hand sequences for stall, reset and overlap cases.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          busy_cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_hi, cur_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = md_op_e'(op);
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.md_op   = MD_NONE;
        bus.d_is_md = 1'b0;
    endtask

    // Called at a negedge; issues one op and waits for the unit to go idle
    task automatic run_op(input vec_t v);
        int n;
        logic exp_stall;
        exp_stall = (v.op >= 3'd1) && (v.op <= 3'd4);
        bus.d_is_md = 1'b1;
        issue(v.op, v.a, v.b);
        #1 check({v.name, " stall@issue"}, 32'(bus.md_stall), 32'(exp_stall));
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            check({v.name, " hi hold"}, bus.hi, cur_hi);
            check({v.name, " lo hold"}, bus.lo, cur_lo);
            n++;
            @(negedge clk);
        end
        check({v.name, " busy cycles"}, 32'(n), 32'(v.busy_cycles));
        check({v.name, " hi"}, bus.hi, v.hi);
        check({v.name, " lo"}, bus.lo, v.lo);
        cur_hi = v.hi;
        cur_lo = v.lo;
    endtask

    initial begin
        int n;
        vecs[0]  = '{"mult neg",   3'd1, 32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{"multu",      3'd2, 32'hFFFFFFFD, 32'd7,        5,  32'h00000006, 32'hFFFFFFEB};
        vecs[2]  = '{"div neg",    3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu by 0",  3'd4, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"div ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu",       3'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{"mthi",       3'd5, 32'h12345678, 32'h0,        0,  32'h12345678, 32'h0000000E};
        vecs[7]  = '{"mtlo",       3'd6, 32'hCAFEBABE, 32'h0,        0,  32'h12345678, 32'hCAFEBABE};
        vecs[8]  = '{"op none",    3'd0, 32'h11111111, 32'h2,        0,  32'h12345678, 32'hCAFEBABE};
        vecs[9]  = '{"op rsvd",    3'd7, 32'h22222222, 32'h3,        0,  32'h12345678, 32'hCAFEBABE};
        vecs[10] = '{"mult carry", 3'd1, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        vecs[11] = '{"div neg b",  3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};

        reset = 1'b1;
        idle_inputs();
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        bus.d_is_md = 1'b1;
        #1;
        check("reset busy",  32'(bus.busy), 32'd0);
        check("reset hi",    bus.hi, 32'd0);
        check("reset lo",    bus.lo, 32'd0);
        check("reset stall", 32'(bus.md_stall), 32'd0);
        @(negedge clk);
        bus.d_is_md = 1'b0;
        reset  = 1'b0;
        cur_hi = '0;
        cur_lo = '0;

        // Back-to-back: each entry issues at the first idle negedge of the previous one
        foreach (vecs[i]) run_op(vecs[i]);

        // Start pulsed mid-divide is ignored; stall held while busy
        issue(3'd4, 32'd100, 32'd7);
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                issue(3'd1, 32'd5, 32'd5);
                bus.d_is_md = 1'b1;
                #1 check("overlap stall", 32'(bus.md_stall), 32'd1);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        idle_inputs();
        check("overlap busy cycles", 32'(n), 32'd10);
        check("overlap hi", bus.hi, 32'h00000002);
        check("overlap lo", bus.lo, 32'h0000000E);
        repeat (2) @(negedge clk);
        check("overlap no late busy", 32'(bus.busy), 32'd0);

        // Reset in busy cycle 2 discards the pending product
        issue(3'd1, 32'd3, 32'd5);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midop reset busy", 32'(bus.busy), 32'd0);
        check("midop reset hi",   bus.hi, 32'd0);
        check("midop reset lo",   bus.lo, 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post reset busy", 32'(bus.busy), 32'd0);
        check("post reset hi",   bus.hi, 32'd0);
        check("post reset lo",   bus.lo, 32'd0);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        issue(3'd1, 32'd3, 32'd5);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        check("reset vs start busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("reset vs start idle", 32'(bus.busy), 32'd0);
        check("reset vs start lo",   bus.lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
